// File: rtl/cc_miss_req_ctrl.sv
// Cache-miss refill sequencer: pushes each accepted miss to the fill FIFO and issues one AXI AR WRAP burst.
// Optional same-line miss absorption is compiled in with `define CC_MISS_DEDUP_EN.
module cc_miss_req_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_req_valid_i,
  input  logic [31:0]      miss_req_addr_i,
  output logic             miss_req_ready_o,
  input  logic             miss_addr_fifo_full_i,
  output logic             miss_addr_fifo_wren_o,
  output logic [31:0]      miss_addr_fifo_wdata_o,
  output logic [3:0]       mem_arid_o,
  output logic [31:0]      mem_araddr_o,
  output logic [3:0]       mem_arlen_o,
  output logic [2:0]       mem_arsize_o,
  output logic [1:0]       mem_arburst_o,
  output logic             mem_arvalid_o,
  input  logic             mem_arready_i,
  input  logic             mem_rvalid_i,
  input  logic             mem_rready_i,
  input  logic             mem_rlast_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid never waits on ready, and AR payload is held stable while arvalid is high.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] w_outstanding_nxt;
  logic [31:0]      r_araddr;
  logic             w_accept;
  logic             w_rdone;
  logic             w_below_limit;
  logic             w_dedup_hit;

  assign w_rdone       = mem_rvalid_i & mem_rready_i & mem_rlast_i;
  assign w_below_limit = (r_outstanding < CNT_W'(MAX_OUTSTANDING));

`ifdef CC_MISS_DEDUP_EN
  logic [25:0] r_last_line;
  logic        r_last_valid;

  assign w_dedup_hit = (r_state == ST_IDLE) & miss_req_valid_i & r_last_valid
                     & (miss_req_addr_i[31:6] == r_last_line);

  // The remembered line is only trusted while some refill is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_line  <= '0;
      r_last_valid <= 1'b0;
    end else if (w_accept) begin
      r_last_line  <= miss_req_addr_i[31:6];
      r_last_valid <= 1'b1;
    end else if (w_outstanding_nxt == '0) begin
      r_last_valid <= 1'b0;
    end
  end
`else
  assign w_dedup_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    miss_req_ready_o = 1'b0;
    mem_arvalid_o    = 1'b0;
    w_accept         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Gated by rst_n so nothing is accepted or pushed while reset is held.
        miss_req_ready_o = rst_n & (w_dedup_hit | (~miss_addr_fifo_full_i & w_below_limit));
        w_accept         = miss_req_valid_i & miss_req_ready_o & ~w_dedup_hit;
        if (w_accept) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    unique case ({w_accept, w_rdone})
      2'b10:   w_outstanding_nxt = r_outstanding + 1'b1;
      2'b01:   if (r_outstanding != '0) w_outstanding_nxt = r_outstanding - 1'b1;
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_outstanding <= '0;
      r_araddr      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (w_accept) begin
        r_araddr <= {miss_req_addr_i[31:3], 3'b000};
      end
    end
  end

  assign miss_addr_fifo_wren_o  = w_accept;
  assign miss_addr_fifo_wdata_o = w_accept ? miss_req_addr_i : 32'd0;
  assign mem_arid_o             = 4'd0;
  assign mem_araddr_o           = r_araddr;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'd3;
  assign mem_arburst_o          = 2'b10;
  assign outstanding_o          = r_outstanding;
  assign busy_o                 = (r_state != ST_IDLE) | (r_outstanding != '0);

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Self-checking bench for cc_miss_req_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model (expected AR address queue and integer burst count).
module tb_cc_miss_req_ctrl;

  localparam int MAX = 4;
`ifdef CC_MISS_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        miss_req_valid_i;
  logic [31:0] miss_req_addr_i;
  logic        miss_req_ready_o;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic [2:0]  outstanding_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  cc_miss_req_ctrl #(.MAX_OUTSTANDING(MAX), .CNT_W(3)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .miss_req_valid_i       (miss_req_valid_i),
    .miss_req_addr_i        (miss_req_addr_i),
    .miss_req_ready_o       (miss_req_ready_o),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .mem_arid_o             (mem_arid_o),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_rvalid_i           (mem_rvalid_i),
    .mem_rready_i           (mem_rready_i),
    .mem_rlast_i            (mem_rlast_i),
    .outstanding_o          (outstanding_o),
    .busy_o                 (busy_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    miss_req_valid_i      = 1'b0;
    miss_req_addr_i       = 32'd0;
    miss_addr_fifo_full_i = 1'b0;
    mem_arready_i         = 1'b1;
    mem_rvalid_i          = 1'b0;
    mem_rready_i          = 1'b0;
    mem_rlast_i           = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic rlast_pulse();
    mem_rvalid_i = 1'b1;
    mem_rready_i = 1'b1;
    mem_rlast_i  = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    mem_rready_i = 1'b0;
    mem_rlast_i  = 1'b0;
  endtask

  // One miss with arready=1: accept cycle then AR handshake cycle.
  task automatic issue_miss(input logic [31:0] addr);
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = addr;
    mem_arready_i    = 1'b1;
    step();
    miss_req_valid_i = 1'b0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++; if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", miss_req_ready_o); end
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %0b want 0", miss_addr_fifo_wren_o); end
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    n_checks++; if (mem_araddr_o !== 32'd0) begin n_fail++; $display("FAIL reset_araddr: got %h want 0", mem_araddr_o); end
    n_checks++; if ({mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o} !== {4'd0, 4'd7, 3'd3, 2'b10})
      begin n_fail++; $display("FAIL reset_ar_const: got id=%0d len=%0d size=%0d burst=%b", mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_1238;
    mem_arready_i    = 1'b1;
    #1;
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL single_wren: got %0b want 1", miss_addr_fifo_wren_o); end
    n_checks++; if (miss_addr_fifo_wdata_o !== 32'h1238) begin n_fail++; $display("FAIL single_wdata: got %h want 00001238", miss_addr_fifo_wdata_o); end
    step();
    miss_req_valid_i = 1'b0;
    #1;
    n_checks++; if (mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_arvalid: got %0b want 1", mem_arvalid_o); end
    n_checks++; if (mem_araddr_o !== 32'h1238) begin n_fail++; $display("FAIL single_araddr: got %h want 00001238", mem_araddr_o); end
    n_checks++; if ({mem_arlen_o, mem_arsize_o, mem_arburst_o} !== {4'd7, 3'd3, 2'b10})
      begin n_fail++; $display("FAIL single_ar_fields: got len=%0d size=%0d burst=%b", mem_arlen_o, mem_arsize_o, mem_arburst_o); end
    n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL single_outstanding: got %0d want 1", outstanding_o); end
    n_checks++; if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_req: got %0b want 0", miss_req_ready_o); end
    step();
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_drop: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_inflight: got %0b want 1", busy_o); end
    rlast_pulse();
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d want 0", outstanding_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %0b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < MAX; i++) begin
      miss_req_valid_i = 1'b1;
      miss_req_addr_i  = 32'h0000_2000 + 32'(i) * 32'h40;
      #1;
      n_checks++; if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %0b want 1", i, miss_req_ready_o); end
      step();
      miss_req_valid_i = 1'b0;
      step();
    end
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_2400;
    #1;
    n_checks++; if (outstanding_o !== 3'(MAX)) begin n_fail++; $display("FAIL b2b_at_limit: got %0d want %0d", outstanding_o, MAX); end
    n_checks++; if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_limit: got %0b want 0", miss_req_ready_o); end
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL b2b_wren_limit: got %0b want 0", miss_addr_fifo_wren_o); end
    rlast_pulse();
    #1;
    n_checks++; if (outstanding_o !== 3'(MAX - 1)) begin n_fail++; $display("FAIL b2b_after_rlast: got %0d want %0d", outstanding_o, MAX - 1); end
    n_checks++; if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_reopen: got %0b want 1", miss_req_ready_o); end
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL b2b_fifth_push: got %0b want 1", miss_addr_fifo_wren_o); end
    step();
    miss_req_valid_i = 1'b0;
    step();
    n_checks++; if (outstanding_o !== 3'(MAX)) begin n_fail++; $display("FAIL b2b_fifth_count: got %0d want %0d", outstanding_o, MAX); end
    for (int i = 0; i < MAX; i++) rlast_pulse();
  endtask

  task automatic test_ar_stall();
    mem_arready_i = 1'b0;
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_3008;
    step();
    for (int i = 0; i < 5; i++) begin
      miss_req_addr_i = $urandom;
      #1;
      n_checks++; if (mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL stall_arvalid_%0d: got %0b want 1", i, mem_arvalid_o); end
      n_checks++; if (mem_araddr_o !== 32'h3008) begin n_fail++; $display("FAIL stall_araddr_%0d: got %h want 00003008", i, mem_araddr_o); end
      n_checks++; if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready_%0d: got %0b want 0", i, miss_req_ready_o); end
      step();
    end
    miss_req_valid_i = 1'b0;
    mem_arready_i    = 1'b1;
    step();
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_done_arvalid: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_done_ready: got %0b want 1", miss_req_ready_o); end
    n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL stall_count: got %0d want 1", outstanding_o); end
    rlast_pulse();
  endtask

  task automatic test_fifo_full();
    miss_addr_fifo_full_i = 1'b1;
    miss_req_valid_i      = 1'b1;
    miss_req_addr_i       = 32'h0000_4010;
    #1;
    n_checks++; if (miss_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", miss_req_ready_o); end
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL full_wren: got %0b want 0", miss_addr_fifo_wren_o); end
    step();
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL full_arvalid: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL full_count: got %0d want 0", outstanding_o); end
    miss_addr_fifo_full_i = 1'b0;
    #1;
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL full_release_wren: got %0b want 1", miss_addr_fifo_wren_o); end
    step();
    miss_req_valid_i = 1'b0;
    n_checks++; if (mem_araddr_o !== 32'h4010) begin n_fail++; $display("FAIL full_release_araddr: got %h want 00004010", mem_araddr_o); end
    step();
    rlast_pulse();
  endtask

  task automatic test_coincident();
    issue_miss(32'h0000_5000);
    issue_miss(32'h0000_5040);
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_5080;
    mem_rvalid_i = 1'b1; mem_rready_i = 1'b1; mem_rlast_i = 1'b1;
    #1;
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL coin_push: got %0b want 1", miss_addr_fifo_wren_o); end
    step();
    miss_req_valid_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rready_i = 1'b0; mem_rlast_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd2) begin n_fail++; $display("FAIL coin_count: got %0d want 2", outstanding_o); end
    step();
    rlast_pulse();
    rlast_pulse();
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL coin_drain: got %0d want 0", outstanding_o); end
    rlast_pulse();
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL coin_floor: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_reset_mid();
    mem_arready_i    = 1'b0;
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_6000;
    step();
    miss_req_valid_i = 1'b0;
    n_checks++; if (mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_arvalid: got %0b want 1", mem_arvalid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_arvalid: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", outstanding_o); end
    step();
    rst_n = 1'b1;
    mem_arready_i = 1'b1;
    step();
    rlast_pulse();
    n_checks++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_stale_rlast: got %0d want 0", outstanding_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b want 0", busy_o); end
  endtask

`ifdef CC_MISS_DEDUP_EN
  task automatic test_dedup();
    issue_miss(32'h0000_1240);
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_1278;
    miss_addr_fifo_full_i = 1'b1;
    #1;
    n_checks++; if (miss_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL dedup_ready: got %0b want 1", miss_req_ready_o); end
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL dedup_wren: got %0b want 0", miss_addr_fifo_wren_o); end
    step();
    miss_req_valid_i = 1'b0;
    miss_addr_fifo_full_i = 1'b0;
    n_checks++; if (mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL dedup_arvalid: got %0b want 0", mem_arvalid_o); end
    n_checks++; if (outstanding_o !== 3'd1) begin n_fail++; $display("FAIL dedup_count: got %0d want 1", outstanding_o); end
    rlast_pulse();
    miss_req_valid_i = 1'b1;
    miss_req_addr_i  = 32'h0000_1240;
    #1;
    n_checks++; if (miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL dedup_repush: got %0b want 1", miss_addr_fifo_wren_o); end
    step();
    miss_req_valid_i = 1'b0;
    n_checks++; if (mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL dedup_reissue: got %0b want 1", mem_arvalid_o); end
    step();
    rlast_pulse();
  endtask
`endif

  // Randomized traffic against a transaction-level reference: integer burst count,
  // a pending-AR flag and the expected AR address queue.
  task automatic test_random();
    int          cnt;
    bit          pending;
    bit          lv;
    logic [25:0] ll;
    bit          hit, e_ready, e_wren, done;
    logic [31:0] a;
    apply_reset();
    cnt = 0; pending = 0; lv = 0; ll = '0;
    exp_q.delete();
    for (int c = 0; c < 2000; c++) begin
      a = 32'h0001_0000 + (32'($urandom_range(0, 7)) << 6) + 32'($urandom_range(0, 63));
      miss_req_valid_i      = ($urandom_range(0, 1) == 1);
      miss_req_addr_i       = a;
      miss_addr_fifo_full_i = ($urandom_range(0, 4) == 0);
      mem_arready_i         = ($urandom_range(0, 4) > 1);
      mem_rvalid_i          = ($urandom_range(0, 3) != 0);
      mem_rready_i          = ($urandom_range(0, 3) != 0);
      mem_rlast_i           = ($urandom_range(0, 2) == 0);
      #1;
      hit     = DEDUP && !pending && miss_req_valid_i && lv && (a[31:6] == ll);
      e_ready = pending ? 1'b0 : (hit ? 1'b1 : (!miss_addr_fifo_full_i && cnt < MAX));
      e_wren  = miss_req_valid_i && e_ready && !hit;
      done    = mem_rvalid_i && mem_rready_i && mem_rlast_i;
      n_checks++; if (miss_req_ready_o !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, miss_req_ready_o, e_ready); end
      n_checks++; if (miss_addr_fifo_wren_o !== e_wren) begin n_fail++; $display("FAIL rnd_wren c=%0d: got %0b want %0b", c, miss_addr_fifo_wren_o, e_wren); end
      if (e_wren) begin
        n_checks++; if (miss_addr_fifo_wdata_o !== a) begin n_fail++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, miss_addr_fifo_wdata_o, a); end
      end
      n_checks++; if (mem_arvalid_o !== pending) begin n_fail++; $display("FAIL rnd_arvalid c=%0d: got %0b want %0b", c, mem_arvalid_o, pending); end
      if (pending && exp_q.size() > 0) begin
        n_checks++; if (mem_araddr_o !== exp_q[0]) begin n_fail++; $display("FAIL rnd_araddr c=%0d: got %h want %h", c, mem_araddr_o, exp_q[0]); end
      end
      n_checks++; if (outstanding_o !== 3'(cnt)) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, outstanding_o, cnt); end
      n_checks++; if (busy_o !== (pending || cnt != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, busy_o, (pending || cnt != 0)); end
      if (pending && mem_arready_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pending = 0;
      end
      if (e_wren) begin
        exp_q.push_back({a[31:3], 3'b000});
        pending = 1;
      end
      if (e_wren && !done) cnt++;
      else if (!e_wren && done && cnt > 0) cnt--;
      if (e_wren) begin
        lv = 1; ll = a[31:6];
      end else if (cnt == 0) begin
        lv = 0;
      end
      step();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ar_stall();
    test_fifo_full();
    test_coincident();
    test_reset_mid();
`ifdef CC_MISS_DEDUP_EN
    test_dedup();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
